// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types for the configurable UART receiver. Holds the
//                parity-mode and receiver-state enumerations and a helper that
//                tells whether a parameter set can be built.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    // True when the receiver can be built with the given parameter set.
    function automatic bit cfg_legal(input int nclks, input int data_bits,
                                     input int parity, input int stop_bits);
        return (nclks >= 4) && (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= 0) && (parity <= 2) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchroniser for the asynchronous serial line. Both
//                flops reset to 1 so an idle line does not look like a start.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                d    - asynchronous input
//                q    - synchronised output (2 cycles behind d)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Parametrised UART receiver with input synchroniser, false
//                start rejection, parity / framing error detection and an
//                AXI-Stream output with backpressure and overrun reporting.
//  Options     : define UART_RX_MAJORITY_EN to take every bit as the 2-of-3
//                majority of the samples around the bit centre (adds one
//                cycle of latency).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rx_data             - asynchronous serial line, idles high
//                axis_out_tdata/tvalid/tready - received payload stream
//                rx_busy             - receiver not in IDLE
//                parity_err, frame_err, overrun_err - one-cycle error pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int NCLKS_PER_BIT = 87,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] axis_out_tdata,
    output logic                 axis_out_tvalid,
    input  logic                 axis_out_tready,
    output logic                 rx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    import uart_pkg::*;

    localparam int c_cnt_w = $clog2(NCLKS_PER_BIT);
    localparam int c_mid   = (NCLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int c_start_decide = c_mid + 1;
`else
    localparam int c_start_decide = c_mid;
`endif
    localparam logic [c_cnt_w-1:0] c_start_pt  = c_cnt_w'(c_start_decide);
    localparam logic [c_cnt_w-1:0] c_bit_end   = c_cnt_w'(NCLKS_PER_BIT - 1);
    localparam logic [3:0]         c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_last_stop = 4'(STOP_BITS - 1);
    localparam parity_e            c_par_mode  = parity_e'(2'(PARITY));

    generate
        if (!cfg_legal(NCLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_cfg
            $error("uart_rx_cfg: illegal parameter set");
        end
    endgenerate

    logic s_rx;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_data),
        .q   (s_rx)
    );

    rx_state_e            r_state,    w_state_n;
    logic [c_cnt_w-1:0]   r_cnt,      w_cnt_n;
    logic [3:0]           r_nbits,    w_nbits_n;
    logic [DATA_BITS-1:0] r_shift,    w_shift_n;
    logic [DATA_BITS-1:0] r_tdata,    w_tdata_n;
    logic                 r_par_bad,  w_par_bad_n;
    logic                 r_stop_bad, w_stop_bad_n;
    logic                 r_tvalid,   w_tvalid_n;
    logic                 r_perr,     w_perr_n;
    logic                 r_ferr,     w_ferr_n;
    logic                 r_oerr,     w_oerr_n;
    logic                 w_bit;
    logic                 w_decide;
    logic                 w_exp_par;

`ifdef UART_RX_MAJORITY_EN
    // Last two s_rx values; with the current one they span MID-1..MID+1
    // when the decision is taken at MID+1.
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], s_rx};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & s_rx) | (r_hist[0] & s_rx);
`else
    assign w_bit = s_rx;
`endif

    // START is timed from the falling edge; later bits are timed a whole
    // bit period after the previous decision, landing on each bit centre.
    assign w_decide  = (r_state == START) ? (r_cnt == c_start_pt) : (r_cnt == c_bit_end);
    assign w_exp_par = (c_par_mode == PARITY_ODD) ? ~^r_shift : ^r_shift;

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = w_decide ? '0 : r_cnt + c_cnt_w'(1);
        w_nbits_n    = r_nbits;
        w_shift_n    = r_shift;
        w_tdata_n    = r_tdata;
        w_par_bad_n  = r_par_bad;
        w_stop_bad_n = r_stop_bad;
        w_tvalid_n   = r_tvalid & ~axis_out_tready;
        w_perr_n     = 1'b0;
        w_ferr_n     = 1'b0;
        w_oerr_n     = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (!s_rx) begin
                    w_state_n = START;
                    // The cycle that saw the edge is the first start-bit cycle.
                    w_cnt_n   = c_cnt_w'(1);
                end
            end
            START: begin
                if (w_decide) begin
                    if (w_bit) begin
                        w_state_n = IDLE;
                    end else begin
                        w_state_n    = DATA;
                        w_nbits_n    = '0;
                        w_par_bad_n  = 1'b0;
                        w_stop_bad_n = 1'b0;
                    end
                end
            end
            DATA: begin
                if (w_decide) begin
                    w_shift_n = {w_bit, r_shift[DATA_BITS-1:1]};
                    if (r_nbits == c_last_data) begin
                        w_nbits_n = '0;
                        w_state_n = (c_par_mode != PARITY_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        w_nbits_n = r_nbits + 4'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (w_decide) begin
                    w_par_bad_n = (w_bit != w_exp_par);
                    w_state_n   = STOP;
                end
            end
            STOP: begin
                if (w_decide) begin
                    w_stop_bad_n = r_stop_bad | ~w_bit;
                    if (r_nbits == c_last_stop) begin
                        w_nbits_n = '0;
                        w_state_n = IDLE;
                        if (w_stop_bad_n) begin
                            w_ferr_n  = 1'b1;
                            w_state_n = WAIT_HIGH;
                        end else if (r_par_bad) begin
                            w_perr_n = 1'b1;
                        end else if (!r_tvalid || axis_out_tready) begin
                            w_tdata_n  = r_shift;
                            w_tvalid_n = 1'b1;
                        end else begin
                            w_oerr_n = 1'b1;
                        end
                    end else begin
                        w_nbits_n = r_nbits + 4'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                // Holds off a break (line stuck low) from framing repeatedly.
                w_cnt_n = '0;
                if (s_rx) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_nbits    <= '0;
            r_shift    <= '0;
            r_tdata    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_tvalid   <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_oerr     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_nbits    <= w_nbits_n;
            r_shift    <= w_shift_n;
            r_tdata    <= w_tdata_n;
            r_par_bad  <= w_par_bad_n;
            r_stop_bad <= w_stop_bad_n;
            r_tvalid   <= w_tvalid_n;
            r_perr     <= w_perr_n;
            r_ferr     <= w_ferr_n;
            r_oerr     <= w_oerr_n;
        end
    end

    assign axis_out_tdata  = r_tdata;
    assign axis_out_tvalid = r_tvalid;
    assign rx_busy         = (r_state != IDLE);
    assign parity_err      = r_perr;
    assign frame_err       = r_ferr;
    assign overrun_err     = r_oerr;

endmodule
`default_nettype wire
